data_memory_controller: RTL and testbench

Data-memory controller directly downstream of the pipeline memory stage. Accepts the stage's read/write request (read, write, memory_addr, data_to_write) and performs the access on an internal word-addressed data RAM after a configurable number of wait states. Returns read_data_from_memory_controller and holds the pipeline with a stall (mem_busy) until the access completes.

---
 rtl/data_memory_controller_if.sv | 24 ++
 rtl/data_memory_controller.sv | 114 +++++++++++
 tb/tb_data_memory_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/data_memory_controller_if.sv
// Request/response bundle between the memory stage and the data-memory controller.
// Signals: read, write, memory_addr, data_to_write, read_data_from_memory_controller, mem_busy, mem_done, mem_misaligned.
interface data_memory_controller_if;
  logic        read;
  logic        write;
  logic [31:0] memory_addr;
  logic [31:0] data_to_write;
  logic [31:0] read_data_from_memory_controller;
  logic        mem_busy;
  logic        mem_done;
  logic        mem_misaligned;

  modport master (
    output read, write, memory_addr, data_to_write,
    input  read_data_from_memory_controller,
    input  mem_busy, mem_done, mem_misaligned
  );

  modport slave (
    input  read, write, memory_addr, data_to_write,
    output read_data_from_memory_controller,
    output mem_busy, mem_done, mem_misaligned
  );
endinterface

// File: rtl/data_memory_controller.sv
// Data-memory controller: word RAM behind an IDLE/ACCESS/RESP FSM with WAIT_CYCLES wait states.
// Ports: clk, rst (sync, active-high), bus (slave modport). Optional macro: MEM_MISALIGN_TRAP_EN.
module data_memory_controller #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic                     clk,
  input logic                     rst,
  data_memory_controller_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    mis_q, mis_d;
  logic                    ram_we;

  logic [31:0] ram [DEPTH];

  // Address bits outside the word index do not select anything.
  logic unused_addr;
  assign unused_addr = ^{bus.memory_addr[31:DEPTH_LOG2+2],
                         bus.memory_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    ram_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.read | bus.write) begin
          // write wins when both are requested
          op_wr_d = bus.write;
          idx_d   = bus.memory_addr[DEPTH_LOG2+1:2];
          wdata_d = bus.data_to_write;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
`ifdef MEM_MISALIGN_TRAP_EN
          if (bus.memory_addr[1:0] != 2'b00) begin
            state_d = RESP;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (op_wr_q) ram_we = 1'b1;
          else         rdata_d = ram[idx_q];
          state_d = RESP;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  // RAM is not cleared by rst; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram[idx_q] <= wdata_q;
  end

  assign bus.read_data_from_memory_controller = rdata_q;
  assign bus.mem_done       = done_q;
  assign bus.mem_misaligned = mis_q;
  assign bus.mem_busy = !rst &
    ((state_q == ACCESS) |
     ((state_q == IDLE) & (bus.read | bus.write)));

endmodule

// File: tb/tb_data_memory_controller.sv
// Scoreboard bench for data_memory_controller with a word-array reference model.
// Driver pushes expected responses; a monitor pops and compares on mem_done.
module tb_data_memory_controller;
  localparam int DL2 = 10;
  localparam int WC  = 2;
  localparam int DEPTH = 1 << DL2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  data_memory_controller_if bus();

  data_memory_controller #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          t0;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model_mem [int];
  logic [31:0] last_rd = 32'h0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & (DEPTH - 1));
  endfunction

  // Monitor: compare every completion against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.mem_done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rdata", bus.read_data_from_memory_controller, e.rd);
        chk("misaligned", 32'(bus.mem_misaligned), 32'(e.mis));
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
        chk("busy_in_resp", 32'(bus.mem_busy), 32'd0);
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    logic mis;
    bit   got;
    @(negedge clk);
    rst = 1'b0;
    bus.read = rd;
    bus.write = wr;
    bus.memory_addr = addr;
    bus.data_to_write = wd;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (addr[1:0] != 2'b00);
`endif
    e.t0 = cyc;
    e.mis = mis;
    e.lat = mis ? 1 : WC + 2;
    if (!mis) begin
      if (wr) model_mem[widx(addr)] = wd;
      else if (model_mem.exists(widx(addr))) last_rd = model_mem[widx(addr)];
      else last_rd = 32'h0;
    end
    e.rd = last_rd;
    sbq.push_back(e);
    #1;
    chk("busy_on_request", 32'(bus.mem_busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs while the access is in flight.
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.memory_addr = $urandom;
    bus.data_to_write = $urandom;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.mem_done) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no mem_done expected mem_done");
    end
  endtask

  initial begin
    bus.read = 1'b1;
    bus.write = 1'b0;
    bus.memory_addr = 32'h0;
    bus.data_to_write = 32'h0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_busy", 32'(bus.mem_busy), 32'd0);
      chk("rst_done", 32'(bus.mem_done), 32'd0);
      chk("rst_rdata", bus.read_data_from_memory_controller, 32'h0);
      chk("rst_mis", 32'(bus.mem_misaligned), 32'd0);
    end
    do_req(1'b1, 1'b0, 32'h0, 32'h0);

    do_req(1'b0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
    do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    do_req(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    do_req(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0005);
    do_req(1'b1, 1'b0, 32'h0000_0020, 32'h0);

    // Reset during the second ACCESS cycle of a write.
    @(negedge clk);
    bus.read = 1'b0;
    bus.write = 1'b1;
    bus.memory_addr = 32'h30;
    bus.data_to_write = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
    chk("abort_done", 32'(bus.mem_done), 32'd0);
    chk("abort_rdata", bus.read_data_from_memory_controller, 32'h0);
    @(negedge clk);
    chk("abort_done_after", 32'(bus.mem_done), 32'd0);
    do_req(1'b1, 1'b0, 32'h0000_0030, 32'h0);

    do_req(1'b0, 1'b1, 32'h0000_0010, 32'h0BAD_F00D);
    do_req(1'b1, 1'b0, 32'h0000_0013, 32'h0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic r, w;
      a = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 7) << 12)
        | $urandom_range(0, 3);
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      do_req(r, w, a, $urandom);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
